// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - programmable one-shot / periodic timer sequencer
//
// timer_counter: saturating up-counter with overflow flag at bit WIDTH
//   clk, rst_n      clock, asynchronous active-low reset
//   load            load cnt_i into the count and clear overflow
//   en              advance by one (ignored once overflow is set)
//   cnt_i           load value
//   cnt_o           low WIDTH bits of the count
//   overflow_o      set when the count has passed 2^WIDTH-1
//
// timer_ctrl: sequences one timer_counter as a prescaled timer
//   clk, rst_n      clock, asynchronous active-low reset
//   start_i         start request (IDLE only)
//   stop_i          abort request, highest priority
//   periodic_i      1 = auto-reload, 0 = one-shot (captured at start)
//   reload_i        start value R (captured at start)
//   prescale_i      prescale value P (captured at start)
//   busy_o          high in LOAD, RUN, EXPIRE
//   irq_o           one-cycle expiry pulse
//   count_o         current counter value

module timer_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] cnt_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             overflow_o
);

  logic [WIDTH:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= {1'b0, cnt_i};
    end else if (en && !count_q[WIDTH]) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign cnt_o      = count_q[WIDTH-1:0];
  assign overflow_o = count_q[WIDTH];

endmodule

module timer_ctrl #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  periodic_i,
  input  logic [WIDTH-1:0]      reload_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  busy_o,
  output logic                  irq_o,
  output logic [WIDTH-1:0]      count_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;
  localparam logic [1:0] EXPIRE = 2'd3;

  logic [1:0]            state_q;
  logic [PRESCALE_W-1:0] pre_q;
  logic [PRESCALE_W-1:0] presc_q;
  logic [WIDTH-1:0]      reload_q;
  logic                  periodic_q;
  logic                  cnt_load;
  logic                  cnt_en;
  logic                  overflow;
  logic                  tick;

  assign tick     = (pre_q == presc_q);
  assign cnt_load = (state_q == LOAD);
  // Once overflow is visible the counter must not move again this run.
  assign cnt_en   = (state_q == RUN) && tick && !overflow;

  timer_counter #(.WIDTH(WIDTH)) u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (cnt_load),
    .en         (cnt_en),
    .cnt_i      (reload_q),
    .cnt_o      (count_o),
    .overflow_o (overflow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pre_q      <= '0;
      presc_q    <= '0;
      reload_q   <= '0;
      periodic_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i && !stop_i) begin
            reload_q   <= reload_i;
            presc_q    <= prescale_i;
            periodic_q <= periodic_i;
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          pre_q   <= '0;
          state_q <= stop_i ? IDLE : RUN;
        end
        RUN: begin
          pre_q <= tick ? '0 : pre_q + 1'b1;
          // Stop wins over a simultaneous overflow: no irq is raised.
          if (stop_i) begin
            state_q <= IDLE;
          end else if (overflow) begin
            state_q <= EXPIRE;
          end
        end
        default: begin
          // Periodic reload reuses the captured config; inputs are ignored.
          state_q <= (periodic_q && !stop_i) ? LOAD : IDLE;
        end
      endcase
    end
  end

  assign busy_o = (state_q != IDLE);
  assign irq_o  = (state_q == EXPIRE);

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - self-checking bench for timer_ctrl
module tb_timer_ctrl;

  localparam int W  = 4;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic          periodic_i = 1'b0;
  logic [W-1:0]  reload_i = '0;
  logic [PW-1:0] prescale_i = '0;
  logic          busy_o;
  logic          irq_o;
  logic [W-1:0]  count_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int held = 0;

  timer_ctrl #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .periodic_i (periodic_i),
    .reload_i   (reload_i),
    .prescale_i (prescale_i),
    .busy_o     (busy_o),
    .irq_o      (irq_o),
    .count_o    (count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r;
    int p;
    bit per;
    int cyc;
    bit busy;
    bit irq;
    int cnt;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input bit b, input bit i, input int c);
    chk({name, ".busy"}, int'(busy_o), int'(b));
    chk({name, ".irq"}, int'(irq_o), int'(i));
    chk({name, ".count"}, int'(count_o), c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start_i = 1'b0;
    stop_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    held = 0;
  endtask

  // Drive a start in cycle 0; returns in cycle 1 with start released.
  task automatic do_start(input int r, input int p, input bit per);
    cyc = 0;
    start_i = 1'b1;
    stop_i = 1'b0;
    reload_i = W'(r);
    prescale_i = PW'(p);
    periodic_i = per;
    step();
    start_i = 1'b0;
  endtask

  // Count seen in run-relative cycle cp (2 <= cp <= period): the k-th
  // increment becomes visible in cycle 2+k(P+1), at most N increments.
  function automatic int run_count(input int cp, input int r, input int p, input int n);
    int inc;
    inc = (cp - 2) / (p + 1);
    if (inc > n) inc = n;
    return (r + inc) % (1 << W);
  endfunction

  initial begin
    vt[0]  = '{14, 0, 0, 2, 1, 0, 14};
    vt[1]  = '{14, 0, 0, 3, 1, 0, 15};
    vt[2]  = '{14, 0, 0, 4, 1, 0, 0};
    vt[3]  = '{14, 0, 0, 5, 1, 1, 0};
    vt[4]  = '{14, 0, 0, 6, 0, 0, 0};
    vt[5]  = '{12, 2, 0, 4, 1, 0, 12};
    vt[6]  = '{12, 2, 0, 5, 1, 0, 13};
    vt[7]  = '{12, 2, 0, 14, 1, 0, 0};
    vt[8]  = '{12, 2, 0, 15, 1, 1, 0};
    vt[9]  = '{15, 1, 1, 5, 1, 1, 0};
    vt[10] = '{15, 1, 1, 6, 1, 0, 0};
    vt[11] = '{15, 1, 1, 7, 1, 0, 15};
    vt[12] = '{15, 1, 1, 10, 1, 1, 0};
    vt[13] = '{0, 0, 0, 17, 1, 0, 15};
    vt[14] = '{0, 0, 0, 18, 1, 0, 0};
    vt[15] = '{0, 0, 0, 19, 1, 1, 0};

    do_reset();
    chk_out("reset", 1'b0, 1'b0, 0);

    // Table-driven checkpoints; config inputs scrambled after start.
    for (int i = 0; i < 16; i++) begin
      do_reset();
      do_start(vt[i].r, vt[i].p, vt[i].per);
      reload_i = W'($urandom);
      prescale_i = PW'($urandom);
      periodic_i = ~vt[i].per;
      while (cyc < vt[i].cyc) begin
        start_i = (cyc % 2) == 1;
        step();
      end
      start_i = 1'b0;
      chk_out($sformatf("vec%0d", i), vt[i].busy, vt[i].irq, vt[i].cnt);
    end

    // Async reset mid-RUN takes effect without a clock edge.
    do_reset();
    do_start(3, 1, 1'b1);
    while (cyc < 6) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_reset", 1'b0, 1'b0, 0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      chk({"post_reset_irq"}, int'(irq_o | busy_o), 0);
    end

    // Stop in the overflow-visible cycle: no irq, IDLE next.
    do_reset();
    do_start(14, 0, 1'b0);
    while (cyc < 4) step();
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    chk_out("stop_ovf", 1'b0, 1'b0, 0);
    step();
    chk_out("stop_ovf_after", 1'b0, 1'b0, 0);

    // Stop during EXPIRE in periodic mode: single irq then IDLE.
    do_reset();
    do_start(15, 1, 1'b1);
    while (cyc < 5) step();
    chk_out("stop_exp_irq", 1'b1, 1'b1, 0);
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    chk_out("stop_exp_idle", 1'b0, 1'b0, 0);
    while (cyc < 12) begin
      step();
      chk("stop_exp_noirq", int'(irq_o), 0);
    end

    // Randomized runs against the arithmetic reference model.
    do_reset();
    for (int trial = 0; trial < 30; trial++) begin
      int r, p, n, t, len, stop_at, cp, ec;
      bit per;
      r = $urandom_range(0, 15);
      p = $urandom_range(0, 3);
      per = 1'($urandom_range(0, 1));
      n = 16 - r;
      t = n * (p + 1) + 3;
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
        start_i = 1'b0;
        stop_i = 1'($urandom_range(0, 1));
        reload_i = W'($urandom);
        chk_out("rnd_idle", 1'b0, 1'b0, held);
        step();
      end
      chk_out("rnd_idle0", 1'b0, 1'b0, held);
      do_start(r, p, per);
      if (per) begin
        len = $urandom_range(1, 2 * t + 3);
        stop_at = len;
      end else begin
        len = t;
        stop_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, t)) : 0;
      end
      for (int c = 1; c <= len; c++) begin
        cp = ((c - 1) % t) + 1;
        if (cp == 1) ec = (c == 1) ? held : 0;
        else ec = run_count(cp, r, p, n);
        chk_out("rnd_run", 1'b1, cp == t, ec);
        start_i = 1'($urandom_range(0, 1));
        stop_i = (c == stop_at);
        reload_i = W'($urandom);
        prescale_i = PW'($urandom);
        periodic_i = 1'($urandom_range(0, 1));
        step();
        if (c == stop_at) begin
          held = (cp == t) ? 0 : run_count(cp + 1, r, p, n);
          break;
        end
      end
      if (!per && stop_at == 0) held = 0;
      start_i = 1'b0;
      stop_i = 1'b0;
    end
    chk_out("rnd_end", 1'b0, 1'b0, held);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
